// File: rtl/map_mem_arbiter.sv
// Arbiter sharing the single-port map memory between the VGA tile fetcher
// (priority) and the NIOS Avalon-MM slave, with a starvation-forced slot.
module map_mem_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int STARVE_LIMIT = 16
) (
    input  logic              Clk,
    input  logic              RESET,
    input  logic              VGA_REQ,
    input  logic [ADDR_W-1:0] VGA_ADDR,
    output logic [31:0]       VGA_DATA,
    output logic              VGA_VALID,
    output logic              VGA_MISS,
    input  logic              AVL_CS,
    input  logic              AVL_READ,
    input  logic              AVL_WRITE,
    input  logic [3:0]        AVL_BYTE_EN,
    input  logic [ADDR_W-1:0] AVL_ADDR,
    input  logic [31:0]       AVL_WRITEDATA,
    output logic [31:0]       AVL_READDATA,
    output logic              AVL_WAITREQUEST,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic              RAM_WREN,
    output logic [3:0]        RAM_BYTEEN,
    output logic [31:0]       RAM_WDATA,
    input  logic [31:0]       RAM_Q
);

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] lat_addr;
    logic [3:0]        lat_be;
    logic [31:0]       lat_wdata;
    logic              lat_write;
    logic [7:0]        stall_cnt;
    logic              avl_req, force_avl, vga_grant, avl_grant;

    assign avl_req   = AVL_CS && (AVL_READ || AVL_WRITE);
    assign force_avl = (state == ISSUE) && (stall_cnt >= 8'(STARVE_LIMIT));
    assign vga_grant = VGA_REQ && !force_avl;
    assign avl_grant = (state == ISSUE) && !vga_grant;

    assign RAM_ADDR        = vga_grant ? VGA_ADDR : lat_addr;
    assign RAM_WREN        = avl_grant && lat_write && (lat_be != 4'h0);
    assign RAM_BYTEEN      = lat_write ? lat_be : 4'hF;
    assign RAM_WDATA       = lat_wdata;
    assign VGA_DATA        = RAM_Q;
    assign AVL_WAITREQUEST = avl_req && (state != DONE);

    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (avl_req) state_nxt = ISSUE;
            ISSUE:   if (avl_grant) state_nxt = lat_write ? DONE : RDWAIT;
            RDWAIT:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latched request, stall counter and registered responses.
    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) begin
            lat_addr     <= '0;
            lat_be       <= '0;
            lat_wdata    <= '0;
            lat_write    <= 1'b0;
            stall_cnt    <= '0;
            VGA_VALID    <= 1'b0;
            VGA_MISS     <= 1'b0;
            AVL_READDATA <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            VGA_VALID <= vga_grant;
            VGA_MISS  <= VGA_REQ && force_avl;
            if (state == IDLE && avl_req) begin
                lat_addr  <= AVL_ADDR;
                lat_be    <= AVL_BYTE_EN;
                lat_wdata <= AVL_WRITEDATA;
                lat_write <= AVL_WRITE;
                stall_cnt <= '0;
            end
            if (state == ISSUE && !avl_grant && stall_cnt != 8'd255) begin
                stall_cnt <= stall_cnt + 8'd1;
            end
            if (state == RDWAIT) begin
                AVL_READDATA <= RAM_Q;
            end
        end
    end

endmodule

// File: tb/tb_map_mem_arbiter.sv
// Scoreboard bench for map_mem_arbiter: behavioural map RAM, shadow memory
// for Avalon read expectations, and queues for VGA and Avalon responses.
module tb_map_mem_arbiter;

    localparam int ADDR_W = 12;

    logic              Clk = 1'b0;
    logic              RESET;
    logic              VGA_REQ;
    logic [ADDR_W-1:0] VGA_ADDR;
    logic [31:0]       VGA_DATA;
    logic              VGA_VALID, VGA_MISS;
    logic              AVL_CS, AVL_READ, AVL_WRITE;
    logic [3:0]        AVL_BYTE_EN;
    logic [ADDR_W-1:0] AVL_ADDR;
    logic [31:0]       AVL_WRITEDATA, AVL_READDATA;
    logic              AVL_WAITREQUEST;
    logic [ADDR_W-1:0] RAM_ADDR;
    logic              RAM_WREN;
    logic [3:0]        RAM_BYTEEN;
    logic [31:0]       RAM_WDATA, RAM_Q;

    map_mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(4)) dut (
        .Clk(Clk), .RESET(RESET),
        .VGA_REQ(VGA_REQ), .VGA_ADDR(VGA_ADDR), .VGA_DATA(VGA_DATA),
        .VGA_VALID(VGA_VALID), .VGA_MISS(VGA_MISS),
        .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
        .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
        .AVL_READDATA(AVL_READDATA), .AVL_WAITREQUEST(AVL_WAITREQUEST),
        .RAM_ADDR(RAM_ADDR), .RAM_WREN(RAM_WREN), .RAM_BYTEEN(RAM_BYTEEN),
        .RAM_WDATA(RAM_WDATA), .RAM_Q(RAM_Q)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        miss;
        logic [31:0] data;
    } vga_exp_t;

    vga_exp_t    vga_exp[$];
    logic [31:0] avl_exp[$];
    logic [31:0] ref_mem [4096];
    logic [31:0] ram [4096];
    logic        preload;
    int          n_vec = 0;
    int          n_err = 0;
    int          wren_cnt = 0;
    int          vga_valid_cnt = 0;
    logic [ADDR_W-1:0] last_wr_addr = '0;
    logic [3:0]  last_wr_be = '0;
    logic        req_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural single-port RAM: byte-enabled write, one-cycle read latency.
    always @(posedge Clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) ram[i] <= 32'(i + 1);
            ram[16] <= 32'hFFFF_FFFF;
        end else if (RAM_WREN) begin
            for (int b = 0; b < 4; b++)
                if (RAM_BYTEEN[b]) ram[RAM_ADDR][b*8 +: 8] <= RAM_WDATA[b*8 +: 8];
        end
        RAM_Q <= ram[RAM_ADDR];
    end

    always @(negedge Clk) begin
        if (RAM_WREN) begin
            wren_cnt     <= wren_cnt + 1;
            last_wr_addr <= RAM_ADDR;
            last_wr_be   <= RAM_BYTEEN;
        end
    end

    // VGA response monitor: a request in one cycle owes a VALID or MISS in the next.
    always @(negedge Clk) begin
        if (req_prev) begin
            if (vga_exp.size() == 0) begin
                check("vga_q_underflow", 32'd1, 32'd0);
            end else begin
                check("vga_kind", {30'd0, VGA_VALID, VGA_MISS},
                      vga_exp[0].miss ? 32'd1 : 32'd2);
                if (!vga_exp[0].miss) check("vga_data", VGA_DATA, vga_exp[0].data);
                void'(vga_exp.pop_front());
            end
        end else if (VGA_VALID || VGA_MISS) begin
            check("vga_spurious", {30'd0, VGA_VALID, VGA_MISS}, 32'd0);
        end
        if (VGA_VALID) vga_valid_cnt <= vga_valid_cnt + 1;
        req_prev <= VGA_REQ && !RESET;
    end

    // Avalon read completion monitor.
    always @(negedge Clk) begin
        if (!RESET && AVL_CS && AVL_READ && !AVL_WRITE && !AVL_WAITREQUEST) begin
            if (avl_exp.size() == 0) begin
                check("avl_unexpected", 32'd1, 32'd0);
            end else begin
                check("avl_rdata", AVL_READDATA, avl_exp[0]);
                void'(avl_exp.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int exp_wait);
        int waits = 0;
        bit done = 0;
        while (!done && waits <= 64) begin
            @(negedge Clk);
            if (!AVL_WAITREQUEST) done = 1;
            else waits++;
        end
        check({tag, "_wait"}, 32'(waits), 32'(exp_wait));
        tick();
        AVL_CS = 1'b0;
        AVL_READ = 1'b0;
        AVL_WRITE = 1'b0;
    endtask

    task automatic avl_start(input logic wr, input logic [ADDR_W-1:0] addr,
                             input logic [3:0] be, input logic [31:0] data);
        AVL_CS = 1'b1;
        AVL_READ = !wr;
        AVL_WRITE = wr;
        AVL_ADDR = addr;
        AVL_BYTE_EN = be;
        AVL_WRITEDATA = data;
        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[addr][b*8 +: 8] = data[b*8 +: 8];
        end else begin
            avl_exp.push_back(ref_mem[addr]);
        end
    endtask

    task automatic avl_xfer(input logic wr, input logic [ADDR_W-1:0] addr, input logic [3:0] be,
                            input logic [31:0] data, input int exp_wait, input string tag);
        avl_start(wr, addr, be, data);
        wait_done(tag, exp_wait);
    endtask

    task automatic vga_drive(input logic [ADDR_W-1:0] addr, input logic miss);
        vga_exp_t e;
        VGA_REQ = 1'b1;
        VGA_ADDR = addr;
        e.miss = miss;
        e.data = ref_mem[addr];
        vga_exp.push_back(e);
        tick();
    endtask

    initial begin
        int w0;
        int v0;
        RESET = 1'b1;
        preload = 1'b1;
        VGA_REQ = 1'b0;
        VGA_ADDR = '0;
        AVL_CS = 1'b0;
        AVL_READ = 1'b0;
        AVL_WRITE = 1'b0;
        AVL_BYTE_EN = '0;
        AVL_ADDR = '0;
        AVL_WRITEDATA = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'(i + 1);
        ref_mem[16] = 32'hFFFF_FFFF;
        #3;
        check("rst_vga_valid", {31'd0, VGA_VALID}, 32'd0);
        check("rst_vga_miss", {31'd0, VGA_MISS}, 32'd0);
        check("rst_readdata", AVL_READDATA, 32'd0);
        check("rst_wren", {31'd0, RAM_WREN}, 32'd0);
        check("rst_ram_addr", 32'(RAM_ADDR), 32'd0);
        check("rst_waitreq", {31'd0, AVL_WAITREQUEST}, 32'd0);
        tick();
        tick();
        preload = 1'b0;
        RESET = 1'b0;
        tick();

        // Plain write then readback with idle VGA.
        w0 = wren_cnt;
        avl_xfer(1'b1, 12'h123, 4'hF, 32'hDEAD_BEEF, 2, "wr123");
        check("wr123_wren_cycles", 32'(wren_cnt - w0), 32'd1);
        check("wr123_addr", 32'(last_wr_addr), 32'h123);
        check("wr123_be", 32'(last_wr_be), 32'hF);
        avl_xfer(1'b0, 12'h123, 4'hF, 32'h0, 3, "rd123");

        // Back-to-back VGA fetches of addresses 0..7.
        v0 = vga_valid_cnt;
        for (int i = 0; i < 8; i++) vga_drive(12'(i), 1'b0);
        VGA_REQ = 1'b0;
        tick();
        tick();
        check("vga_valid_count", 32'(vga_valid_cnt - v0), 32'd8);

        // VGA held high while a read is pending: forced slot on 5th ISSUE cycle.
        fork
            avl_xfer(1'b0, 12'h123, 4'hF, 32'h0, 7, "starve_rd");
            begin
                for (int i = 0; i < 10; i++) vga_drive(12'(i), i == 5);
                VGA_REQ = 1'b0;
            end
        join
        tick();
        tick();

        // Partial byte write and readback.
        w0 = wren_cnt;
        avl_xfer(1'b1, 12'h010, 4'h3, 32'h0000_1234, 2, "wr_be3");
        check("wr_be3_wren_cycles", 32'(wren_cnt - w0), 32'd1);
        check("wr_be3_byteen", 32'(last_wr_be), 32'h3);
        avl_xfer(1'b0, 12'h010, 4'hF, 32'h0, 3, "rd_be3");

        // Byte-enable zero write: completes, never touches the RAM.
        w0 = wren_cnt;
        avl_xfer(1'b1, 12'h200, 4'h0, 32'h5555_5555, 2, "wr_be0");
        check("wr_be0_wren_cycles", 32'(wren_cnt - w0), 32'd0);

        // Asynchronous reset during RDWAIT, then the held read restarts.
        avl_start(1'b0, 12'h010, 4'hF, 32'h0);
        @(negedge Clk);
        @(negedge Clk);
        @(posedge Clk);
        #2;
        RESET = 1'b1;
        #1;
        check("mid_rst_vga_valid", {31'd0, VGA_VALID}, 32'd0);
        check("mid_rst_vga_miss", {31'd0, VGA_MISS}, 32'd0);
        check("mid_rst_readdata", AVL_READDATA, 32'd0);
        check("mid_rst_wren", {31'd0, RAM_WREN}, 32'd0);
        check("mid_rst_ram_addr", 32'(RAM_ADDR), 32'd0);
        tick();
        tick();
        RESET = 1'b0;
        wait_done("rst_restart", 3);
        tick();
        tick();

        check("vga_q_empty", 32'(vga_exp.size()), 32'd0);
        check("avl_q_empty", 32'(avl_exp.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/map_mem_arbiter.md
Name: map_mem_arbiter

Overview:
- Shares the single-port on-chip map memory (4096 x 32, one-cycle read latency) between two masters: the VGA tile-fetch path and the NIOS Avalon-MM slave.
- The VGA path has priority. Avalon accesses are sequenced through a small FSM with waitrequest.
- A starvation counter guarantees that Avalon transfers complete even during long active-video runs.

Parameters:
- ADDR_W, 12, word address width of map memory and both request ports
- STARVE_LIMIT, 16, consecutive lost ISSUE cycles after which Avalon takes one forced slot (legal range 1..255)

Ports:
- Clk  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- VGA_REQ  in  1  VGA fetch request this cycle
- VGA_ADDR  in  ADDR_W  VGA fetch word address
- VGA_DATA  out  32  fetched word; equals RAM_Q, meaningful only when VGA_VALID=1
- VGA_VALID  out  1  fetch data valid; pulses one cycle after a granted VGA_REQ
- VGA_MISS  out  1  pulses in place of VGA_VALID when the VGA request was pre-empted
- AVL_CS  in  1  Avalon chip select
- AVL_READ  in  1  Avalon read
- AVL_WRITE  in  1  Avalon write
- AVL_BYTE_EN  in  4  Avalon byte enables
- AVL_ADDR  in  ADDR_W  Avalon word address
- AVL_WRITEDATA  in  32  Avalon write data
- AVL_READDATA  out  32  Avalon read data, registered
- AVL_WAITREQUEST  out  1  Avalon waitrequest
- RAM_ADDR  out  ADDR_W  memory address
- RAM_WREN  out  1  memory write enable
- RAM_BYTEEN  out  4  memory byte enables
- RAM_WDATA  out  32  memory write data
- RAM_Q  in  32  memory read data; valid the cycle after RAM_ADDR is presented

Behaviour:
- Reset (async, any time, including mid-transfer):
  - FSM goes to IDLE; stall counter = 0; force flag = 0.
  - VGA_VALID = VGA_MISS = 0; AVL_READDATA = 0; latched Avalon request cleared.
  - RAM_WREN = 0, RAM_ADDR = 0.
- Grant (combinational):
  - vga_grant = VGA_REQ and not force_avl.
  - avl_grant = (state == ISSUE) and not vga_grant.
  - RAM_ADDR = VGA_ADDR when vga_grant, else the latched Avalon address.
  - RAM_WREN = avl_grant and latched op = write and latched BE != 0.
  - RAM_BYTEEN = latched BE on writes, 4'hF otherwise.
  - RAM_WDATA = latched write data.
- VGA response:
  - VGA_VALID(t+1) = vga_grant(t).
  - VGA_MISS(t+1) = VGA_REQ(t) and force_avl(t).
  - VGA_DATA = RAM_Q (combinational passthrough).
- Avalon FSM: IDLE, ISSUE, RDWAIT, DONE.
  - IDLE: if AVL_CS and (AVL_READ or AVL_WRITE), latch addr, BE, writedata and op (write wins if both asserted); clear stall counter; go to ISSUE.
  - ISSUE:
    - If avl_grant and write: go to DONE.
    - If avl_grant and read: go to RDWAIT.
    - Otherwise stay in ISSUE; stall counter += 1, saturating at 255.
  - RDWAIT: AVL_READDATA <= RAM_Q; go to DONE.
  - DONE: go to IDLE.
- AVL_WAITREQUEST = AVL_CS and (AVL_READ or AVL_WRITE) and state != DONE. The transfer completes in the single DONE cycle.
- Minimum latency, request to waitrequest low:
  - Write: 2 cycles (IDLE, ISSUE).
  - Read: 3 cycles (IDLE, ISSUE, RDWAIT).
- A new request is accepted in IDLE the cycle after DONE; there are no back-to-back completions.
- Starvation:
  - force_avl = (state == ISSUE) and (stall counter >= STARVE_LIMIT).
  - The forced slot is one cycle. The counter clears on the next entry to ISSUE.
- The master holds all Avalon inputs stable while waitrequest is high. If AVL_CS drops mid-transfer, the FSM still finishes using the latched request and returns to IDLE. Writes are not cancelled.
- A write with BE = 0 completes normally and issues no RAM write.
- AVL_READDATA holds its last value until the next read's RDWAIT.
- Simultaneous VGA_REQ and Avalon ISSUE: VGA wins unless force_avl is set.

Test Plan:
- Idle VGA, Avalon write addr 0x123 data 0xDEADBEEF BE 0xF:
  - RAM_WREN=1 for exactly 1 cycle, RAM_ADDR=0x123.
  - waitrequest low on cycle 3 after the request.
  - Read of 0x123 returns 0xDEADBEEF with waitrequest low on cycle 4.
- VGA_REQ every cycle, addresses 0..7, with model RAM q=addr+1:
  - VGA_VALID high on cycles 1..8.
  - VGA_DATA = 1..8 in order.
  - VGA_MISS never set.
- VGA_REQ held high, Avalon read pending, STARVE_LIMIT=4:
  - Avalon gets RAM on the 5th ISSUE cycle.
  - Exactly one VGA_MISS pulse, coincident with the RDWAIT cycle.
  - Read completes with the correct data.
- Avalon write BE=0x3 to 0x010 holding 0xFFFFFFFF, data 0x00001234:
  - RAM_BYTEEN=0x3.
  - Readback is 0xFFFF1234.
- Write with BE=0:
  - RAM_WREN never asserts.
  - waitrequest still drops after 2 cycles.
- RESET asserted while in RDWAIT:
  - All outputs 0 immediately, without a clock edge.
  - After release, with AVL_READ still high, the read restarts from IDLE and completes normally.
